alu_flags_ir_core: RTL and testbench

- Execute-stage datapath slice of the ARM-style multicycle CPU.
- Contains three parts:
  - a combinational 32-bit ALU driven by a 5-bit operation code;
  - a 4-bit flag register (FDR) holding {N,Z,C,V}, loaded from the ALU flags;
  - a 32-bit instruction register (IR) loaded from memory data-out.
- The control unit drives the op, load enables and operands. The condition tester consumes ir_q[31:28] and flags_q.

---
 rtl/alu_flags_ir_core.sv | 158 +++++++++++++++
 tb/tb_alu_flags_ir_core.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_flags_ir_core.sv
// Execute-stage slice: 32-bit ALU, NZCV flag register and instruction register (optional ALU_CARRY_FROM_FDR_EN takes cin from stored C).
// Latency: ALU result/flags are combinational (0 cycles); flags_q and ir_q update one rising CLK edge after their load enable.
// Backpressure: none; loads are fire-and-forget enables and CLR (async, active-low) overrides every load.
module alu_flags_ir_core #(
   parameter int                DATA_W = 32,
   parameter logic [DATA_W-1:0] PC_INC = 4
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [4:0]        op,
   input  logic              carry_in,
   input  logic              fr_ld,
   input  logic              ir_ld,
   input  logic [DATA_W-1:0] ir_in,
   output logic [DATA_W-1:0] result,
   output logic              flag_n,
   output logic              flag_z,
   output logic              flag_c,
   output logic              flag_v,
   output logic [3:0]        flags_q,
   output logic [DATA_W-1:0] ir_q
);

   // ARM data-processing opcodes plus the extended control-unit ops
   localparam logic [4:0] OP_AND = 5'd0;
   localparam logic [4:0] OP_EOR = 5'd1;
   localparam logic [4:0] OP_SUB = 5'd2;
   localparam logic [4:0] OP_RSB = 5'd3;
   localparam logic [4:0] OP_ADD = 5'd4;
   localparam logic [4:0] OP_ADC = 5'd5;
   localparam logic [4:0] OP_SBC = 5'd6;
   localparam logic [4:0] OP_RSC = 5'd7;
   localparam logic [4:0] OP_TST = 5'd8;
   localparam logic [4:0] OP_TEQ = 5'd9;
   localparam logic [4:0] OP_CMP = 5'd10;
   localparam logic [4:0] OP_CMN = 5'd11;
   localparam logic [4:0] OP_ORR = 5'd12;
   localparam logic [4:0] OP_MOV = 5'd13;
   localparam logic [4:0] OP_BIC = 5'd14;
   localparam logic [4:0] OP_MVN = 5'd15;
   localparam logic [4:0] OP_PCI = 5'd16;
   localparam logic [4:0] OP_PSA = 5'd17;
   localparam logic [4:0] OP_PSB = 5'd18;
   localparam logic [4:0] OP_AAD = 5'd19;
   localparam logic [4:0] OP_ASU = 5'd20;

   logic              cin;
   logic [DATA_W-1:0] add_x;
   logic [DATA_W-1:0] add_y;
   logic              add_c;
   logic              is_arith;
   logic [DATA_W-1:0] logic_res;
   logic [DATA_W:0]   sum_w;
   logic [3:0]        flags_d;
   logic [DATA_W-1:0] ir_d;

`ifdef ALU_CARRY_FROM_FDR_EN
   // Stored C feeds the carry chain; the external carry pin is kept only for pin compatibility
   logic unused_carry_in;
   assign unused_carry_in = carry_in;
   assign cin             = flags_q[1];
`else
   assign cin = carry_in;
`endif

   // Operand steering: every arithmetic op is expressed as x + y + c on one shared adder,
   // subtractions use the inverted operand so the adder carry-out is ARM's NOT-borrow
   always_comb begin
      add_x     = a;
      add_y     = b;
      add_c     = 1'b0;
      is_arith  = 1'b0;
      logic_res = '0;
      case (op)
         OP_AND, OP_TST: logic_res = a & b;
         OP_EOR, OP_TEQ: logic_res = a ^ b;
         OP_ORR:         logic_res = a | b;
         OP_MOV, OP_PSB: logic_res = b;
         OP_BIC:         logic_res = a & ~b;
         OP_MVN:         logic_res = ~b;
         OP_PSA:         logic_res = a;
         OP_SUB, OP_CMP, OP_ASU: begin
            add_y    = ~b;
            add_c    = 1'b1;
            is_arith = 1'b1;
         end
         OP_RSB: begin
            add_x    = b;
            add_y    = ~a;
            add_c    = 1'b1;
            is_arith = 1'b1;
         end
         OP_ADD, OP_CMN, OP_AAD: begin
            is_arith = 1'b1;
         end
         OP_ADC: begin
            add_c    = cin;
            is_arith = 1'b1;
         end
         OP_SBC: begin
            add_y    = ~b;
            add_c    = cin;
            is_arith = 1'b1;
         end
         OP_RSC: begin
            add_x    = b;
            add_y    = ~a;
            add_c    = cin;
            is_arith = 1'b1;
         end
         OP_PCI: begin
            add_y    = PC_INC;
            is_arith = 1'b1;
         end
         // 21..31 and unknown codes yield zero
         default: logic_res = '0;
      endcase
   end

   // 33-bit adder; bit DATA_W is the carry out
   assign sum_w = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_c};

   // Result select and flag generation; non-arithmetic ops pass cin to C and keep the stored V
   always_comb begin
      result = is_arith ? sum_w[DATA_W-1:0] : logic_res;
      flag_n = result[DATA_W-1];
      flag_z = (result == '0);
      if (is_arith) begin
         flag_c = sum_w[DATA_W];
         flag_v = (add_x[DATA_W-1] == add_y[DATA_W-1]) &&
                  (sum_w[DATA_W-1] != add_x[DATA_W-1]);
      end else begin
         flag_c = cin;
         flag_v = flags_q[0];
      end
   end

   // Next-state for the flag and instruction registers: capture only when enabled
   always_comb begin
      flags_d = fr_ld ? {flag_n, flag_z, flag_c, flag_v} : flags_q;
      ir_d    = ir_ld ? ir_in : ir_q;
   end

   // Flag register: async clear dominates, otherwise follows flags_d
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) flags_q <= 4'b0000;
      else      flags_q <= flags_d;
   end

   // Instruction register: async clear dominates, otherwise follows ir_d
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) ir_q <= '0;
      else      ir_q <= ir_d;
   end

endmodule

// File: tb/tb_alu_flags_ir_core.sv
// Bench for alu_flags_ir_core: table of ALU vectors plus reset, hold and async-clear sequences.
// Latency: expected ALU outputs checked between edges, registered outputs checked #1 after posedge.
// Backpressure: none; stimulus is driven on the falling edge.
module tb_alu_flags_ir_core;

   logic        CLK = 1'b0;
   logic        CLR;
   logic [31:0] a, b, ir_in;
   logic [4:0]  op;
   logic        carry_in, fr_ld, ir_ld;
   logic [31:0] result, ir_q;
   logic        flag_n, flag_z, flag_c, flag_v;
   logic [3:0]  flags_q;

   int n_vec = 0;
   int n_err = 0;
   logic [3:0] model_fq = 4'b0000;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        fr;
      logic [31:0] exp_res;
      logic [3:0]  exp_nzcv;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  nzcv;
   } exp_t;

   vec_t tbl[25];
   exp_t sb[$];

   alu_flags_ir_core dut (
      .CLK(CLK), .CLR(CLR), .a(a), .b(b), .op(op), .carry_in(carry_in),
      .fr_ld(fr_ld), .ir_ld(ir_ld), .ir_in(ir_in), .result(result),
      .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
      .flags_q(flags_q), .ir_q(ir_q)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one ALU vector, check combinational outputs via the scoreboard, then the flag register
   task automatic apply(input string nm, input logic [4:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic c, input logic fr,
                        input logic [31:0] er, input logic [3:0] en);
      exp_t e;
      @(negedge CLK);
      op = o; a = va; b = vb; carry_in = c; fr_ld = fr; ir_ld = 1'b0;
      e.res = er; e.nzcv = en;
      sb.push_back(e);
      #2;
      if (sb.size() == 0) begin
         chk({nm, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({nm, "_res"}, result, e.res);
         chk({nm, "_nzcv"}, {28'd0, flag_n, flag_z, flag_c, flag_v}, {28'd0, e.nzcv});
      end
      @(posedge CLK); #1;
      if (fr) model_fq = en;
      chk({nm, "_fq"}, {28'd0, flags_q}, {28'd0, model_fq});
      fr_ld = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{5'd4,  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 4'b1001};
      tbl[1]  = '{5'd10, 32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 4'b0110};
      tbl[2]  = '{5'd2,  32'h00000003, 32'h00000005, 1'b0, 1'b0, 32'hFFFFFFFE, 4'b1000};
      tbl[3]  = '{5'd5,  32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 4'b0110};
      tbl[4]  = '{5'd16, 32'h00000008, 32'h00000000, 1'b0, 1'b0, 32'h0000000C, 4'b0000};
      tbl[5]  = '{5'd13, 32'h00000000, 32'h00001234, 1'b1, 1'b0, 32'h00001234, 4'b0010};
      tbl[6]  = '{5'd15, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1000};
      tbl[7]  = '{5'd25, 32'h00000123, 32'h00000456, 1'b1, 1'b0, 32'h00000000, 4'b0110};
      tbl[8]  = '{5'd4,  32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 4'b0111};
      tbl[9]  = '{5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'hF000F000, 4'b1001};
      tbl[10] = '{5'd1,  32'hFFFF0000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0000FFFF, 4'b0011};
      tbl[11] = '{5'd3,  32'h00000001, 32'h00000000, 1'b0, 1'b0, 32'hFFFFFFFF, 4'b1000};
      tbl[12] = '{5'd6,  32'h00000005, 32'h00000003, 1'b0, 1'b0, 32'h00000001, 4'b0010};
      tbl[13] = '{5'd7,  32'h00000003, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 4'b0010};
      tbl[14] = '{5'd8,  32'h0000000F, 32'h000000F0, 1'b0, 1'b0, 32'h00000000, 4'b0101};
      tbl[15] = '{5'd9,  32'h0000AAAA, 32'h0000AAAA, 1'b1, 1'b0, 32'h00000000, 4'b0111};
      tbl[16] = '{5'd11, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 4'b0110};
      tbl[17] = '{5'd12, 32'h00FF0000, 32'h0000FF00, 1'b0, 1'b0, 32'h00FFFF00, 4'b0001};
      tbl[18] = '{5'd14, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 1'b0, 32'hFFFF0000, 4'b1001};
      tbl[19] = '{5'd17, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 32'h80000000, 4'b1001};
      tbl[20] = '{5'd18, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 4'b0111};
      tbl[21] = '{5'd19, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 4'b1001};
      tbl[22] = '{5'd5,  32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 4'b1001};
      tbl[23] = '{5'd20, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 4'b0011};
      tbl[24] = '{5'd2,  32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 4'b0110};

      // Reset held with both loads asserted and the clock running
      CLR = 1'b0; fr_ld = 1'b1; ir_ld = 1'b1; ir_in = 32'hDEADBEEF;
      op = 5'd4; a = 32'h1; b = 32'h1; carry_in = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_fq", {28'd0, flags_q}, 32'd0);
      chk("rst_ir", ir_q, 32'd0);

      // Release reset, then one IR capture
      @(negedge CLK);
      CLR = 1'b1; fr_ld = 1'b0; ir_ld = 1'b1; ir_in = 32'hE3A01005;
      @(posedge CLK); #1;
      chk("ir_cap", ir_q, 32'hE3A01005);
      chk("ir_cap_fq", {28'd0, flags_q}, 32'd0);
      @(negedge CLK);
      ir_ld = 1'b0; ir_in = 32'h11111111;
      @(posedge CLK); #1;
      chk("ir_hold", ir_q, 32'hE3A01005);

`ifdef ALU_CARRY_FROM_FDR_EN
      // Carry sourced from stored C; carry_in pin is ignored
      apply("fdr_c0_set", 5'd4, 32'h0, 32'h0, 1'b1, 1'b1, 32'h00000000, 4'b0100);
      apply("fdr_adc0", 5'd5, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF, 4'b1000);
      apply("fdr_c1_set", 5'd10, 32'h5, 32'h5, 1'b0, 1'b1, 32'h00000000, 4'b0110);
      apply("fdr_adc1", 5'd5, 32'h1, 32'h1, 1'b0, 1'b0, 32'h00000003, 4'b0000);
`else
      foreach (tbl[i]) begin
         apply($sformatf("vec%0d_op%0d", i, tbl[i].op), tbl[i].op, tbl[i].a, tbl[i].b,
               tbl[i].cin, tbl[i].fr, tbl[i].exp_res, tbl[i].exp_nzcv);
      end
`endif

      // Flags hold across three edges with fr_ld low and changing ALU outputs
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         fr_ld = 1'b0; op = 5'd4; a = 32'h80000000 + i; b = 32'hFFFFFFFF;
         @(posedge CLK); #1;
         chk($sformatf("hold%0d_fq", i), {28'd0, flags_q}, {28'd0, model_fq});
      end

      // Both loads in the same cycle
      @(negedge CLK);
      op = 5'd4; a = 32'h80000000; b = 32'h80000000; carry_in = 1'b0;
      fr_ld = 1'b1; ir_ld = 1'b1; ir_in = 32'h12345678;
      @(posedge CLK); #1;
      model_fq = 4'b0111;
      chk("dual_fq", {28'd0, flags_q}, {28'd0, model_fq});
      chk("dual_ir", ir_q, 32'h12345678);

      // Async clear between edges with loads pending
      @(negedge CLK);
      op = 5'd10; a = 32'h5; b = 32'h5; fr_ld = 1'b1; ir_ld = 1'b1; ir_in = 32'hCAFEF00D;
      #2 CLR = 1'b0;
      #1;
      chk("aclr_fq", {28'd0, flags_q}, 32'd0);
      chk("aclr_ir", ir_q, 32'd0);
      op = 5'd0; a = 32'h0; b = 32'h0; carry_in = 1'b0;
      #1;
      chk("aclr_vkeep", {28'd0, flag_n, flag_z, flag_c, flag_v}, 32'b0100);
      @(posedge CLK); #1;
      chk("aclr_dom_fq", {28'd0, flags_q}, 32'd0);
      chk("aclr_dom_ir", ir_q, 32'd0);
      @(negedge CLK);
      CLR = 1'b1; fr_ld = 1'b0; ir_ld = 1'b0;
      @(posedge CLK); #1;
      chk("rel_ir", ir_q, 32'd0);
      chk("sb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
